// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the frequency divider bank.
// No datapath here, so there is no latency and no backpressure.
package freq_div_pkg;

   localparam int DEFAULT_WIDTH = 15;
   localparam int DEFAULT_DIV   = 32050;
   localparam int MAX_CH        = 16;

   // Channel-select width; a single channel still gets a 1-bit select so an out-of-range value is expressible.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: 0..div counter, active/pending divisor, toggling Clock_out and registered tick.
// Tick and toggle appear one edge after count == div; no backpressure, optional sync under FREQ_DIV_SYNC_EN.
module divider_channel
   import freq_div_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int RST_DIV = DEFAULT_DIV
) (
   input  logic             Clock_in,
   input  logic             Reset,
   input  logic             enable,
`ifdef FREQ_DIV_SYNC_EN
   input  logic             sync,
`endif
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [WIDTH-1:0] RST_DIV_W = WIDTH'(RST_DIV);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] active_div;
   logic [WIDTH-1:0] pending_div;
   logic             wrap;

   // count never exceeds active_div because the divisor only changes when count returns to 0
   assign wrap = enable && (count == active_div);

   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset) begin
         count       <= '0;
         active_div  <= RST_DIV_W;
         pending_div <= RST_DIV_W;
         clk_out     <= 1'b0;
         tick        <= 1'b0;
      end else begin
         if (load) begin
            pending_div <= load_value;
         end
         // active_div takes the pre-edge pending value, so a load on the wrap edge waits one more period
`ifdef FREQ_DIV_SYNC_EN
         if (sync) begin
            count      <= '0;
            active_div <= pending_div;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
         end else
`endif
         if (wrap) begin
            count      <= '0;
            active_div <= pending_div;
            clk_out    <= ~clk_out;
            tick       <= 1'b1;
         end else begin
            tick <= 1'b0;
            if (enable) begin
               count <= count + WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/freq_divider_bank.sv
// Bank of NUM_CH clock dividers sharing one divisor-load port; Load_ack/Load_err one cycle after Load, no backpressure.
// Optional all-channel Sync input is built only when FREQ_DIV_SYNC_EN is defined.
module freq_divider_bank #(
   parameter int NUM_CH      = 4,
   parameter int WIDTH       = freq_div_pkg::DEFAULT_WIDTH,
   parameter int DEFAULT_DIV = freq_div_pkg::DEFAULT_DIV
) (
   input  logic                                     Clock_in,
   input  logic                                     Reset,
   input  logic                                     Enable,
   input  logic                                     Load,
   input  logic [freq_div_pkg::ch_width(NUM_CH)-1:0] Load_ch,
   input  logic [WIDTH-1:0]                         Load_value,
`ifdef FREQ_DIV_SYNC_EN
   input  logic                                     Sync,
`endif
   output logic                                     Load_ack,
   output logic                                     Load_err,
   output logic [NUM_CH-1:0]                        Clock_out,
   output logic [NUM_CH-1:0]                        Tick
);

   logic              load_ok;
   logic [NUM_CH-1:0] ch_load;

   // Non-power-of-two banks leave select codes with no channel behind them; those are rejected.
   assign load_ok = Load && (32'(Load_ch) < NUM_CH);

   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset) begin
         Load_ack <= 1'b0;
         Load_err <= 1'b0;
      end else begin
         Load_ack <= load_ok;
         Load_err <= Load && !load_ok;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign ch_load[g] = load_ok && (32'(Load_ch) == g);

      divider_channel #(
         .WIDTH   (WIDTH),
         .RST_DIV (DEFAULT_DIV)
      ) u_ch (
         .Clock_in   (Clock_in),
         .Reset      (Reset),
         .enable     (Enable),
`ifdef FREQ_DIV_SYNC_EN
         .sync       (Sync),
`endif
         .load       (ch_load[g]),
         .load_value (Load_value),
         .clk_out    (Clock_out[g]),
         .tick       (Tick[g])
      );
   end

endmodule

// File: tb/tb_freq_divider_bank.sv
// Directed bench for freq_divider_bank with three channels and the default 32050 reset divisor.
// Inputs change and outputs are sampled on the falling edge of Clock_in.
module tb_freq_divider_bank;

   localparam int NUM_CH = 3;
   localparam int WIDTH  = 15;
   localparam int T0     = 32051;  // first wrap edge after reset release with DEFAULT_DIV

   logic              Clock_in = 1'b0;
   logic              Reset;
   logic              Enable;
   logic              Load;
   logic [1:0]        Load_ch;
   logic [WIDTH-1:0]  Load_value;
`ifdef FREQ_DIV_SYNC_EN
   logic              Sync;
`endif
   logic              Load_ack;
   logic              Load_err;
   logic [NUM_CH-1:0] Clock_out;
   logic [NUM_CH-1:0] Tick;

   int total = 0;
   int bad   = 0;
   int n     = 0;

   always #5 Clock_in = ~Clock_in;

   freq_divider_bank #(
      .NUM_CH      (NUM_CH),
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (32050)
   ) dut (
      .Clock_in   (Clock_in),
      .Reset      (Reset),
      .Enable     (Enable),
      .Load       (Load),
      .Load_ch    (Load_ch),
      .Load_value (Load_value),
`ifdef FREQ_DIV_SYNC_EN
      .Sync       (Sync),
`endif
      .Load_ack   (Load_ack),
      .Load_err   (Load_err),
      .Clock_out  (Clock_out),
      .Tick       (Tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s at n=%0d: observed=%0h expected=%0h", tag, n, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(negedge Clock_in);
         n++;
      end
   endtask

   task automatic do_load(input logic [1:0] ch, input logic [WIDTH-1:0] val);
      Load       = 1'b1;
      Load_ch    = ch;
      Load_value = val;
   endtask

   initial begin
      int d;
      Reset = 1'b0; Enable = 1'b1; Load = 1'b0; Load_ch = '0; Load_value = '0;
`ifdef FREQ_DIV_SYNC_EN
      Sync = 1'b0;
`endif
      #1 Reset = 1'b1;
      #1;
      chk("rst_clock_out", 32'(Clock_out), 0);
      chk("rst_tick",      32'(Tick), 0);
      chk("rst_ack",       32'(Load_ack), 0);
      chk("rst_err",       32'(Load_err), 0);
      repeat (3) @(negedge Clock_in);
      Reset = 1'b0;
      n = 0;

      // Load ch1=9, ch2=0, ch1=3 (overwrites), then an invalid channel
      do_load(2'd1, 15'd9);
      step(1);
      chk("ack_ch1_a", 32'(Load_ack), 1);
      chk("err_ch1_a", 32'(Load_err), 0);
      do_load(2'd2, 15'd0);
      step(1);
      chk("ack_ch2", 32'(Load_ack), 1);
      do_load(2'd1, 15'd3);
      step(1);
      chk("ack_ch1_b", 32'(Load_ack), 1);
      do_load(2'd3, 15'd1);
      step(1);
      chk("err_bad_ch", 32'(Load_err), 1);
      chk("noack_bad_ch", 32'(Load_ack), 0);
      Load = 1'b0;
      step(1);
      chk("err_clear", 32'(Load_err), 0);
      chk("ack_clear", 32'(Load_ack), 0);

      // Every channel finishes its DEFAULT_DIV half period regardless of pending loads
      step(T0 - 1 - n);
      chk("pre_wrap_clock_out", 32'(Clock_out), 0);
      chk("pre_wrap_tick",      32'(Tick), 0);
      step(1);
      chk("first_rise_clock_out", 32'(Clock_out), 3'b111);
      chk("first_rise_tick",      32'(Tick), 3'b111);

      // ch0 idle at 1, ch1 period 8, ch2 toggles every cycle
      for (int i = 0; i < 15; i++) begin
         step(1);
         d = n - T0;
         chk("run_clock_out", 32'(Clock_out),
             {29'd0, (d % 2) == 0, ((d / 4) % 2) == 0, 1'b1});
         chk("run_tick", 32'(Tick), {29'd0, 1'b1, (d % 4) == 0, 1'b0});
      end

      // Load ch1=7 on the very edge ch1 wraps: old divisor 3 still governs the next period
      do_load(2'd1, 15'd7);
      step(1);
      Load = 1'b0;
      chk("wrapload_ack",  32'(Load_ack), 1);
      chk("wrapload_clk1", 32'(Clock_out[1]), 1);
      chk("wrapload_tick1", 32'(Tick[1]), 1);
      step(3);
      chk("old_div_tick1_low", 32'(Tick[1]), 0);
      step(1);
      chk("old_div_wrap_clk1",  32'(Clock_out[1]), 0);
      chk("old_div_wrap_tick1", 32'(Tick[1]), 1);
      step(4);
      chk("new_div_no_wrap", 32'(Tick[1]), 0);
      step(4);
      chk("new_div_wrap_clk1",  32'(Clock_out[1]), 1);
      chk("new_div_wrap_tick1", 32'(Tick[1]), 1);

      // ch1 count is 5 here; freeze for 10 edges
      step(5);
      Enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("freeze_clock_out", 32'(Clock_out), 3'b011);
         chk("freeze_tick",      32'(Tick), 0);
      end
      Enable = 1'b1;
      step(2);
      chk("resume_pre_clk1",  32'(Clock_out[1]), 1);
      chk("resume_pre_tick1", 32'(Tick[1]), 0);
      step(1);
      chk("resume_wrap_clk1",  32'(Clock_out[1]), 0);
      chk("resume_wrap_tick1", 32'(Tick[1]), 1);

      // Pending divisor then asynchronous reset between clock edges
      do_load(2'd1, 15'd1);
      step(1);
      Load = 1'b0;
      chk("pre_reset_ack", 32'(Load_ack), 1);
      chk("pre_reset_clk0", 32'(Clock_out[0]), 1);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_clock_out", 32'(Clock_out), 0);
      chk("async_rst_tick",      32'(Tick), 0);
      chk("async_rst_ack",       32'(Load_ack), 0);
      @(negedge Clock_in);
      Reset = 1'b0;
      n = 0;
      step(20);
      chk("post_reset_clock_out", 32'(Clock_out), 0);
      chk("post_reset_tick",      32'(Tick), 0);

`ifdef FREQ_DIV_SYNC_EN
      do_load(2'd0, 15'd1);
      step(1);
      do_load(2'd1, 15'd2);
      step(1);
      do_load(2'd2, 15'd4);
      step(1);
      Sync = 1'b1;
      do_load(2'd0, 15'd6);
      step(1);
      Sync = 1'b0;
      Load = 1'b0;
      chk("sync_clock_out", 32'(Clock_out), 0);
      chk("sync_tick",      32'(Tick), 0);
      chk("sync_load_ack",  32'(Load_ack), 1);
      step(2);
      chk("sync_ch0_wrap", 32'(Clock_out), 3'b001);
      step(1);
      chk("sync_ch1_wrap", 32'(Clock_out), 3'b011);
      step(2);
      chk("sync_ch2_wrap", 32'(Clock_out), 3'b111);
      step(4);
      chk("sync_staggered", 32'(Clock_out), 3'b110);
      Sync   = 1'b1;
      Enable = 1'b0;
      step(1);
      Sync   = 1'b0;
      Enable = 1'b1;
      chk("resync_clock_out", 32'(Clock_out), 0);
      chk("resync_tick",      32'(Tick), 0);
      step(3);
      chk("resync_ch1_first", 32'(Clock_out), 3'b010);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freq_divider_bank.md
FREQ_DIVIDER_BANK -- requirements
Module: freq_divider_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 15, counter/divisor width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 32050, reset divisor of every channel.
REQ-004 SHALL have port Clock_in  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Enable  input  1  global run; low freezes all channels.
REQ-007 SHALL have port Load  input  1  single-cycle request to write a channel divisor.
REQ-008 SHALL have port Load_ch  input  clog2(NUM_CH) (min 1)  target channel of Load.
REQ-009 SHALL have port Load_value  input  WIDTH  new divisor value.
REQ-010 SHALL have port Load_ack  output  1  one-cycle acknowledge of an accepted Load.
REQ-011 SHALL have port Load_err  output  1  one-cycle flag: Load rejected, Load_ch >= NUM_CH.
REQ-012 SHALL have port Clock_out  output  NUM_CH  per-channel divided clock, 50% duty.
REQ-013 SHALL have port Tick  output  NUM_CH  per-channel one-cycle pulse on each Clock_out toggle.

Function
REQ-014 Each channel SHALL count 0..div; on count == div with Enable high: count <= 0, Clock_out toggles, Tick = 1 that cycle (registered).
REQ-015 Output period SHALL be 2*(div+1) Clock_in cycles; div = 0 gives Clock_in/2, Tick every cycle.
REQ-016 Enable low SHALL hold count and Clock_out, force Tick to 0; counting resumes from held count on re-enable.
REQ-017 Load SHALL write Load_value into that channel's pending register; Load_ack SHALL assert the next cycle.
REQ-018 Pending divisor SHALL become active only at the channel's next wrap (count == div), never mid-period.
REQ-019 Second Load to the same channel before its wrap SHALL overwrite pending; last value wins.
REQ-020 Load with Load_ch >= NUM_CH SHALL change no state, pulse Load_err next cycle, no Load_ack.
REQ-021 Load on the same cycle as that channel's wrap SHALL apply at the following wrap, not the current one.
REQ-022 Comparison SHALL be on the active divisor; counter arithmetic SHALL be unsigned WIDTH bits, no overflow possible.

Reset
REQ-023 Reset SHALL asynchronously set count = 0, active and pending divisor = DEFAULT_DIV, Clock_out = 0, Tick = 0, Load_ack = 0, Load_err = 0.
REQ-024 Reset mid-period or with a pending Load SHALL discard the pending value.

Configuration
REQ-025 With macro FREQ_DIV_SYNC_EN defined, SHALL add input port Sync (1 bit).
REQ-026 Sync high SHALL, next edge, clear all counts, set all Clock_out to 0, Tick to 0, and apply all pending divisors.
REQ-027 Sync SHALL win over wrap and Enable; Load in the same cycle SHALL be captured as pending, applied at next wrap.
REQ-028 Without FREQ_DIV_SYNC_EN the Sync port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-029 Shared package freq_div_pkg SHALL hold DEFAULT_WIDTH (15), DEFAULT_DIV (32050), MAX_CH (16).
REQ-030 One sub-module divider_channel SHALL implement a single channel (count, active/pending divisor, toggle, tick), instantiated NUM_CH times by generate.
REQ-031 Top level SHALL hold Load decode, Load_ack/Load_err registers and Sync fan-out.

Verification
REQ-032 Reset release, DEFAULT_DIV=32050, Enable=1 -> Clock_out[0] first rises after 32051 cycles, period 64102 cycles.
REQ-033 Load ch1 value 3 mid-period -> Load_ack next cycle; ch1 completes old period, then period 8 cycles.
REQ-034 Load div 0 on ch2 -> after next wrap Clock_out[2] toggles every cycle, Tick[2] constantly high.
REQ-035 Enable low 10 cycles at count 5 -> count, Clock_out frozen, Tick 0; wrap delayed exactly 10 cycles.
REQ-036 NUM_CH=3, Load_ch=3 -> Load_err one cycle, no Load_ack, no channel change.
REQ-037 FREQ_DIV_SYNC_EN: Sync pulse with staggered channels -> all Clock_out 0 and aligned; Reset asserted mid-period -> all outputs 0 immediately.
